seq_datapath: RTL and testbench

Parametrised, self-sequencing successor to the single-bus CPU datapath. It holds an NREGS×WIDTH register file, Y, ZHI/ZLO, HI and LO on one internal bus. An internal control FSM executes one register-transfer instruction per start pulse: operand A goes to Y, operand B is combined through the ALU, and the result is written back. MUL and DIV are multi-cycle iterative units, which the original fixed 32-bit datapath did not provide.

---
 rtl/seq_datapath.sv | 223 ++++++++++++++++++++++
 tb/tb_seq_datapath.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_datapath.sv
// seq_datapath: single-bus register-transfer datapath with an internal sequencer.
// Executes one instruction per accepted start; MUL/DIV iterate WIDTH cycles.
`default_nettype none

module seq_datapath #(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [AW-1:0]    ra_i,
  input  logic [AW-1:0]    rb_i,
  input  logic [AW-1:0]    rd_i,
  input  logic [WIDTH-1:0] imm_in_i,
  input  logic [AW-1:0]    dbg_sel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o,
  output logic             illegal_op_o,
  output logic [WIDTH-1:0] dbg_data_o
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_DIV  = 4'd8;
  localparam logic [3:0] OP_LDI  = 4'd9;
  localparam logic [3:0] OP_MFHI = 4'd10;
  localparam logic [3:0] OP_MFLO = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TA   = 3'd1,
    S_TB   = 3'd2,
    S_ITER = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t           state_q;
  logic [3:0]       op_q;
  logic [AW-1:0]    ra_q, rb_q, rd_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] y_q, b_q, zhi_q, zlo_q, hi_q, lo_q, result_q;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dbz_q, ill_q;

  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] alu_hi_d, alu_lo_d;
  logic [WIDTH-1:0] step_hi_d, step_lo_d;
  logic [WIDTH:0]   add_sum, sub_dif, mul_sum, div_rem, div_dif;
  logic             div_ge;
  logic             is_iter_op, is_illegal;

  assign is_iter_op = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign is_illegal = (op_q >= 4'd12);

  always_comb begin
    bus = '0;
    case (state_q)
      S_TA: bus = regs_q[ra_q];
      S_TB: begin
        case (op_q)
          OP_LDI:  bus = imm_q;
          OP_MFHI: bus = hi_q;
          OP_MFLO: bus = lo_q;
          default: bus = regs_q[rb_q];
        endcase
      end
      S_WB:    bus = zlo_q;
      default: bus = '0;
    endcase
  end

  assign add_sum = {1'b0, y_q} + {1'b0, bus};
  assign sub_dif = {1'b0, y_q} - {1'b0, bus};

  always_comb begin
    alu_hi_d = '0;
    alu_lo_d = bus;
    case (op_q)
      OP_ADD: begin
        alu_lo_d = add_sum[WIDTH-1:0];
        alu_hi_d = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
      end
      OP_SUB: begin
        alu_lo_d = sub_dif[WIDTH-1:0];
        alu_hi_d = {{(WIDTH-1){1'b0}}, sub_dif[WIDTH]};
      end
      OP_AND:  alu_lo_d = y_q & bus;
      OP_OR:   alu_lo_d = y_q | bus;
      OP_XOR:  alu_lo_d = y_q ^ bus;
      OP_SHL:  alu_lo_d = y_q << bus[SW-1:0];
      OP_SHR:  alu_lo_d = y_q >> bus[SW-1:0];
      default: alu_lo_d = bus;
    endcase
  end

  // ZHI:ZLO doubles as the iteration accumulator: multiplier/dividend start in ZLO.
  assign mul_sum = {1'b0, zhi_q} + (zlo_q[0] ? {1'b0, y_q} : {(WIDTH+1){1'b0}});
  assign div_rem = {zhi_q, zlo_q[WIDTH-1]};
  assign div_dif = div_rem - {1'b0, b_q};
  assign div_ge  = (div_rem >= {1'b0, b_q});

  always_comb begin
    step_hi_d = '0;
    step_lo_d = '0;
    if (op_q == OP_MUL) begin
      step_hi_d = mul_sum[WIDTH:1];
      step_lo_d = {mul_sum[0], zlo_q[WIDTH-1:1]};
    end else begin
      step_hi_d = div_ge ? div_dif[WIDTH-1:0] : div_rem[WIDTH-1:0];
      step_lo_d = {zlo_q[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      y_q      <= '0;
      b_q      <= '0;
      zhi_q    <= '0;
      zlo_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            op_q    <= op_i;
            ra_q    <= ra_i;
            rb_q    <= rb_i;
            rd_q    <= rd_i;
            imm_q   <= imm_in_i;
            busy_q  <= 1'b1;
            dbz_q   <= 1'b0;
            ill_q   <= 1'b0;
            state_q <= S_TA;
          end
        end
        S_TA: begin
          y_q     <= bus;
          state_q <= S_TB;
        end
        S_TB: begin
          b_q <= bus;
          if (is_iter_op) begin
            zhi_q   <= '0;
            zlo_q   <= (op_q == OP_MUL) ? bus : y_q;
            cnt_q   <= CW'(WIDTH - 1);
            state_q <= S_ITER;
          end else begin
            zhi_q   <= alu_hi_d;
            zlo_q   <= alu_lo_d;
            state_q <= S_WB;
          end
        end
        S_ITER: begin
          zhi_q <= step_hi_d;
          zlo_q <= step_lo_d;
          if (cnt_q == '0) state_q <= S_WB;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_WB: begin
          if (is_illegal) begin
            ill_q <= 1'b1;
          end else begin
            regs_q[rd_q] <= bus;
            result_q     <= bus;
            if (is_iter_op) begin
              hi_q <= zhi_q;
              lo_q <= zlo_q;
            end
            if ((op_q == OP_DIV) && (b_q == '0)) dbz_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign result_o      = result_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_q;
  assign illegal_op_o  = ill_q;
  assign dbg_data_o    = regs_q[dbg_sel_i];

endmodule

`default_nettype wire

// File: tb/tb_seq_datapath.sv
// Self-checking bench for seq_datapath: directed cases plus randomized
// instructions against an arithmetic reference model.
`default_nettype none

module tb_seq_datapath;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic [3:0]  op, ra, rb, rd, dbg_sel;
  logic [31:0] imm;
  logic        busy, done, dbz, ill;
  logic [31:0] result, hi, lo, dbg_data;

  logic        s_start;
  logic [3:0]  s_op;
  logic [1:0]  s_ra, s_rb, s_rd, s_dbg_sel;
  logic [7:0]  s_imm;
  logic        s_busy, s_done, s_dbz, s_ill;
  logic [7:0]  s_result, s_hi, s_lo, s_dbg_data;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] m_regs [16];
  logic [31:0] m_hi, m_lo, m_result;
  logic        m_dbz, m_ill;

  always #5 clk = ~clk;

  seq_datapath #(.WIDTH(32), .NREGS(16)) u_dut (
    .clk_i(clk), .clr_ni(clr_n), .start_i(start), .op_i(op),
    .ra_i(ra), .rb_i(rb), .rd_i(rd), .imm_in_i(imm), .dbg_sel_i(dbg_sel),
    .busy_o(busy), .done_o(done), .result_o(result), .hi_o(hi), .lo_o(lo),
    .div_by_zero_o(dbz), .illegal_op_o(ill), .dbg_data_o(dbg_data)
  );

  seq_datapath #(.WIDTH(8), .NREGS(4)) u_dut8 (
    .clk_i(clk), .clr_ni(clr_n), .start_i(s_start), .op_i(s_op),
    .ra_i(s_ra), .rb_i(s_rb), .rd_i(s_rd), .imm_in_i(s_imm), .dbg_sel_i(s_dbg_sel),
    .busy_o(s_busy), .done_o(s_done), .result_o(s_result), .hi_o(s_hi), .lo_o(s_lo),
    .div_by_zero_o(s_dbz), .illegal_op_o(s_ill), .dbg_data_o(s_dbg_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_hi = '0; m_lo = '0; m_result = '0; m_dbz = 1'b0; m_ill = 1'b0;
  endtask

  // Reference behaviour straight from the operation rules.
  task automatic model_exec(input logic [3:0] o, input int a_i, input int b_i,
                            input int d_i, input logic [31:0] im);
    logic [31:0] a, b, r;
    logic [63:0] p;
    m_dbz = 1'b0;
    m_ill = 1'b0;
    a = m_regs[a_i];
    b = (o == 9) ? im : (o == 10) ? m_hi : (o == 11) ? m_lo : m_regs[b_i];
    r = '0;
    case (o)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a << b[4:0];
      6: r = a >> b[4:0];
      7: begin
        p = 64'(a) * 64'(b);
        m_hi = p[63:32];
        m_lo = p[31:0];
        r = p[31:0];
      end
      8: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a; m_dbz = 1'b1;
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
        r = m_lo;
      end
      9, 10, 11: r = b;
      default: m_ill = 1'b1;
    endcase
    if (!m_ill) begin
      m_regs[d_i] = r;
      m_result = r;
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i);
      #1;
      check_eq(tag, {32'd0, dbg_data}, {32'd0, m_regs[i]});
    end
  endtask

  // Issues one instruction, scrambles the inputs after acceptance, and checks
  // latency, busy length, writeback, HI/LO and flags. poke pulses a stray ADD->R5.
  task automatic run_instr(input logic [3:0] o, input int a_i, input int b_i,
                           input int d_i, input logic [31:0] im, input bit poke);
    int lat, bcnt, exp_lat;
    @(negedge clk);
    op = o; ra = 4'(a_i); rb = 4'(b_i); rd = 4'(d_i); imm = im; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom); rd = 4'($urandom); imm = $urandom;
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      if (poke && lat == 6) begin
        start = 1'b1; op = 4'd0; ra = 4'd1; rb = 4'd2; rd = 4'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
    end
    start = 1'b0;
    model_exec(o, a_i, b_i, d_i, im);
    exp_lat = (o == 7 || o == 8) ? 35 : 3;
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("busy_cycles", 64'(bcnt), 64'(exp_lat));
    check_eq("busy_with_done", {63'd0, busy}, 64'd0);
    check_eq("result", {32'd0, result}, {32'd0, m_result});
    check_eq("hi", {32'd0, hi}, {32'd0, m_hi});
    check_eq("lo", {32'd0, lo}, {32'd0, m_lo});
    check_eq("div_by_zero", {63'd0, dbz}, {63'd0, m_dbz});
    check_eq("illegal_op", {63'd0, ill}, {63'd0, m_ill});
    dbg_sel = 4'(d_i);
    #1;
    check_eq("rd_value", {32'd0, dbg_data}, {32'd0, m_regs[d_i]});
    @(posedge clk);
    #1;
    check_eq("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  task automatic run8(input logic [3:0] o, input int a_i, input int b_i, input int d_i,
                      input logic [7:0] im, output int lat);
    @(negedge clk);
    s_op = o; s_ra = 2'(a_i); s_rb = 2'(b_i); s_rd = 2'(d_i); s_imm = im; s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    lat = 0;
    while (!s_done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat8;
    int done_seen;
    logic [3:0] ro;
    clr_n = 1'b0; start = 1'b0; op = '0; ra = '0; rb = '0; rd = '0; imm = '0; dbg_sel = '0;
    s_start = 1'b0; s_op = '0; s_ra = '0; s_rb = '0; s_rd = '0; s_imm = '0; s_dbg_sel = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_result", {32'd0, result}, 64'd0);
    check_eq("rst_hilo", {hi, lo}, 64'd0);
    check_eq("rst_flags", {62'd0, dbz, ill}, 64'd0);
    check_all_regs("rst_regs");
    @(negedge clk);
    clr_n = 1'b1;

    run_instr(4'd9, 0, 0, 1, 32'hFFFF_FFFF, 1'b0);
    run_instr(4'd9, 0, 0, 2, 32'h0000_0001, 1'b0);
    run_instr(4'd0, 1, 2, 3, 32'h0, 1'b0);
    check_eq("add_wrap", {32'd0, result}, 64'd0);

    run_instr(4'd9, 0, 0, 2, 32'hFFFF_FFFF, 1'b0);
    run_instr(4'd7, 1, 2, 3, 32'h0, 1'b0);
    check_eq("mul_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_instr(4'd9, 0, 0, 1, 32'd100, 1'b0);
    run_instr(4'd9, 0, 0, 2, 32'd7, 1'b0);
    run_instr(4'd8, 1, 2, 3, 32'h0, 1'b0);
    check_eq("div_100_7", {hi, lo}, {32'd2, 32'd14});
    run_instr(4'd9, 0, 0, 2, 32'd0, 1'b0);
    run_instr(4'd8, 1, 2, 3, 32'h0, 1'b0);
    check_eq("div_zero", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
    check_eq("div_zero_flag", {63'd0, dbz}, 64'd1);
    run_instr(4'd0, 1, 1, 4, 32'h0, 1'b0);
    check_eq("dbz_cleared", {63'd0, dbz}, 64'd0);

    run_instr(4'd9, 0, 0, 5, 32'h5555_AAAA, 1'b0);
    run_instr(4'd7, 1, 1, 6, 32'h0, 1'b1);
    dbg_sel = 4'd5;
    #1;
    check_eq("start_while_busy_r5", {32'd0, dbg_data}, 64'h5555_AAAA);

    run_instr(4'd13, 1, 2, 7, 32'h0, 1'b0);
    check_eq("illegal_flag", {63'd0, ill}, 64'd1);
    check_all_regs("illegal_regs");

    // Abort a MUL to R4 after ten iteration steps.
    @(negedge clk);
    op = 4'd7; ra = 4'd1; rb = 4'd5; rd = 4'd4; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    clr_n = 1'b0;
    model_reset();
    #1;
    check_eq("abort_busy_done", {62'd0, busy, done}, 64'd0);
    check_eq("abort_hilo", {hi, lo}, 64'd0);
    check_eq("abort_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check_eq("abort_no_done", 64'(done_seen), 64'd0);
    check_all_regs("abort_regs");
    run_instr(4'd10, 0, 0, 1, 32'h0, 1'b0);
    check_eq("mfhi_after_reset", {32'd0, dbg_data}, 64'd0);

    for (int i = 0; i < 16; i++)
      run_instr(4'd9, 0, 0, i, (i == 0) ? 32'd0 : $urandom, 1'b0);
    for (int n = 0; n < 120; n++) begin
      ro = 4'($urandom_range(0, 15));
      if (ro >= 4'd12 && ($urandom_range(0, 3) != 0)) ro = 4'($urandom_range(0, 11));
      run_instr(ro, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom, 1'b0);
    end
    check_all_regs("random_regs");

    run8(4'd9, 0, 0, 0, 8'h81, lat8);
    run8(4'd9, 0, 0, 1, 8'h01, lat8);
    run8(4'd5, 0, 1, 0, 8'h00, lat8);
    check_eq("w8_shl_lat", 64'(lat8), 64'd3);
    check_eq("w8_shl", {56'd0, s_result}, 64'h02);
    run8(4'd9, 0, 0, 2, 8'hFF, lat8);
    run8(4'd7, 2, 2, 3, 8'h00, lat8);
    check_eq("w8_mul_lat", 64'(lat8), 64'd11);
    check_eq("w8_mul", {48'd0, s_hi, s_lo}, 64'hFE01);
    s_dbg_sel = 2'd3;
    #1;
    check_eq("w8_mul_r3", {56'd0, s_dbg_data}, 64'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
